myproject_mul_acc_pipe: RTL and testbench
=========================================

// Module: myproject_mul_acc_pipe
// PURPOSE
//  Parametrised, pipelined successor of the combinational signed x unsigned HLS multiplier.
//  Computes din0 (signed) x din1 (unsigned), optionally accumulates over a kernel window.
//  Rescales by SHIFT and saturates to dout_WIDTH; valid/ready handshake on both sides.
//  Sits in the pruned-CNN datapath between the weight/activation streams and the bias/ReLU stage.
// PARAMETERS
//  din0_WIDTH  16  signed operand width (activation)
//  din1_WIDTH  14  unsigned operand width (weight magnitude / scale)
//  dout_WIDTH  29  output width, saturated, signed
//  NUM_STAGE   2   multiplier register stages, 1..4
//  ACC_EN      0   0: one output per input; 1: accumulate ACC_LEN products per output
//  ACC_LEN     9   products per accumulation group, 1..256 (used when ACC_EN=1)
//  SHIFT       0   arithmetic right shift applied before saturation, 0..PROD_W-1
// PORTS
//  ap_clk     in   1           clock, rising edge
//  ap_rst_n   in   1           asynchronous active-low reset
//  din0       in   din0_WIDTH  signed operand
//  din1       in   din1_WIDTH  unsigned operand, zero-extended by 1 bit
//  in_valid   in   1           input beat valid
//  in_last    in   1           closes an accumulation group early (ignored when ACC_EN=0)
//  in_ready   out  1           input beat accepted when in_valid & in_ready
//  dout       out  dout_WIDTH  result, signed
//  out_valid  out  1           result valid; held stable until out_ready
//  out_ready  in   1           downstream accepts
//  out_sat    out  1           dout was clipped; qualified by out_valid
// BEHAVIOUR
//  Widths: PROD_W = din0_WIDTH+din1_WIDTH+1; ACC_W = PROD_W+clog2(ACC_LEN).
//  Product and sums are exact; no wrap inside the accumulator.
//  Rescale: floor (arithmetic >>>SHIFT, toward -inf), then clip to [-2^(dout_WIDTH-1), 2^(dout_WIDTH-1)-1].
//  out_sat=1 iff clipped.
//  Reset: all pipe valid bits, out_valid, out_sat, dout, accumulator and group counter = 0.
//  in_ready=1 one cycle after reset release (0 while ap_rst_n low).
//  Pipeline: global stall en = ~out_valid | out_ready; in_ready = en.
//  All stages advance only when en=1, and bubbles advance too.
//  Latency ACC_EN=0: accepted beat -> out_valid after exactly NUM_STAGE+1 cycles when unstalled.
//  Throughput is 1/cycle.
//  ACC_EN=1: the accumulate stage follows the multiplier.
//   Counter cnt 0..ACC_LEN-1.
//   First product of a group loads acc; later products add.
//   Group closes when cnt==ACC_LEN-1 or when in_last travels with the product.
//   Both conditions in the same beat -> exactly one output.
//   On close: result registered to output one cycle later; cnt and acc clear for the next beat.
//   No lost cycle: the first beat of the next group may arrive in the cycle after close.
//   Output stall while an accumulation continues: pipe stops (en=0); no product is dropped or double-added.
//  out_valid & ~out_ready: dout, out_sat held stable.
//  Reset mid-operation: partial group discarded, no output emitted.
//  in_valid=0 cycles: inject bubbles and do not advance cnt.
//  in_last with ACC_EN=0: ignored.
// STRUCTURE
//  Package myproject_mac_pkg: clog2 function.
//  Package also holds PROD_W/ACC_W derivation and the sat_shift function (shift + clip + flag).
//  Sub-module myproject_mul_pipe_stage: signed x {0,unsigned} multiplier with NUM_STAGE registers.
//   It has an enable input and carries a side-band {valid,last} shift register.
//  Top holds accumulator, counter, rescale/saturate and output register.
// TESTING
//  ACC_EN=0, NUM_STAGE=2: din0=-3, din1=5, out_ready=1 -> dout=-15, out_sat=0, 3 cycles after accept.
//  ACC_EN=1, ACC_LEN=9: nine beats din0=100, din1=200 -> single dout=180000 after the 9th; cnt back to 0.
//  ACC_EN=1: in_last on beat 4 of din0=1, din1=1 -> dout=4.
//   Next group of 9 ones -> dout=9.
//   Also drive in_last on beat 9 -> exactly one output.
//  dout_WIDTH=16, din0=32767, din1=16383 -> dout=32767, out_sat=1.
//   din0=-32768, din1=16383 -> dout=-32768, out_sat=1.
//   SHIFT=4, din0=-1, din1=1 -> dout=-1 (floor).
//  Random out_ready at 30% with streaming input: sum of outputs = golden model, no beat lost or duplicated.
//   dout stable while stalled.
//  Pull ap_rst_n low mid-group (after 5 of 9 beats) -> outputs 0 immediately.
//   Next full group of 9 ones after release -> dout=9.

Source files
------------

// File: rtl/myproject_mac_pkg.sv
// Shared width derivations and the rescale/saturate helper for the multiply-accumulate pipe.
//   clog2      : ceiling log2, clog2(1) = 0
//   prod_w     : exact width of signed x {0,unsigned} product
//   acc_w      : accumulator width that cannot wrap over len products
//   sat_shift  : arithmetic right shift (floor) then clip to a signed out_w range, with clip flag
package myproject_mac_pkg;

    // Working width of sat_shift; every datapath value is sign-extended to this first.
    localparam int unsigned MAX_W = 64;

    typedef struct packed {
        logic signed [MAX_W-1:0] val;
        logic                    sat;
    } sat_res_t;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v << 1;
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int unsigned prod_w(input int unsigned a_w, input int unsigned b_w);
        // Unsigned operand gains a zero sign bit.
        return a_w + b_w + 1;
    endfunction

    function automatic int unsigned acc_w(input int unsigned p_w, input int unsigned len);
        return p_w + clog2(len);
    endfunction

    function automatic sat_res_t sat_shift(input logic signed [MAX_W-1:0] x,
                                           input int unsigned             shift,
                                           input int unsigned             out_w);
        sat_res_t                res;
        logic signed [MAX_W-1:0] s;
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        s       = x >>> shift;
        hi      = $signed((MAX_W'(1) << (out_w - 1)) - MAX_W'(1));
        lo      = ~hi;
        res.val = s;
        res.sat = 1'b0;
        if (s > hi) begin
            res.val = hi;
            res.sat = 1'b1;
        end else if (s < lo) begin
            res.val = lo;
            res.sat = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/myproject_mul_pipe_stage.sv
// Signed x {0,unsigned} multiplier followed by NUM_STAGE enable-gated registers, with a matching
// side-band {valid,last} shift register so bubbles travel with the data.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : advance all stages
//   i_valid/i_last : beat qualifiers entering with the operands
//   i_a, i_b       : signed operand, unsigned operand
//   o_valid/o_last : qualifiers leaving the last stage
//   o_prod         : exact product from the last stage
module myproject_mul_pipe_stage
    import myproject_mac_pkg::*;
#(
    parameter int unsigned DIN0_W    = 16,
    parameter int unsigned DIN1_W    = 14,
    parameter int unsigned NUM_STAGE = 2,
    localparam int unsigned PROD_W   = prod_w(DIN0_W, DIN1_W)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_en,
    input  logic                     i_valid,
    input  logic                     i_last,
    input  logic [DIN0_W-1:0]        i_a,
    input  logic [DIN1_W-1:0]        i_b,
    output logic                     o_valid,
    output logic                     o_last,
    output logic signed [PROD_W-1:0] o_prod
);

    logic signed [PROD_W-1:0] w_prod;
    logic signed [PROD_W-1:0] r_prod [NUM_STAGE];
    logic [NUM_STAGE-1:0]     r_valid;
    logic [NUM_STAGE-1:0]     r_last;

    // Both operands are extended to PROD_W in signed context, so the product is exact.
    assign w_prod = $signed(i_a) * $signed({1'b0, i_b});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_valid <= '0;
            r_last  <= '0;
            for (int i = 0; i < int'(NUM_STAGE); i++) begin
                r_prod[i] <= '0;
            end
        end else if (i_en) begin
            r_valid[0] <= i_valid;
            r_last[0]  <= i_last & i_valid;
            r_prod[0]  <= w_prod;
            for (int i = 1; i < int'(NUM_STAGE); i++) begin
                r_valid[i] <= r_valid[i-1];
                r_last[i]  <= r_last[i-1];
                r_prod[i]  <= r_prod[i-1];
            end
        end
    end

    assign o_valid = r_valid[NUM_STAGE-1];
    assign o_last  = r_last[NUM_STAGE-1];
    assign o_prod  = r_prod[NUM_STAGE-1];

endmodule

// File: rtl/myproject_mul_acc_pipe.sv
// Pipelined signed x unsigned multiplier with optional kernel-window accumulation, floor rescale
// and signed saturation, valid/ready on both sides with a single global stall.
//   ap_clk, ap_rst_n   : clock, asynchronous active-low reset
//   din0, din1         : signed / unsigned operands
//   in_valid, in_last  : input beat, early group close (accumulate mode only)
//   in_ready           : input accepted when in_valid & in_ready
//   dout, out_sat      : saturated result and clip flag, qualified by out_valid
//   out_valid          : held with dout/out_sat until out_ready
//   out_ready          : downstream accepts
module myproject_mul_acc_pipe
    import myproject_mac_pkg::*;
#(
    parameter int unsigned din0_WIDTH = 16,
    parameter int unsigned din1_WIDTH = 14,
    parameter int unsigned dout_WIDTH = 29,
    parameter int unsigned NUM_STAGE  = 2,
    parameter int unsigned ACC_EN     = 0,
    parameter int unsigned ACC_LEN    = 9,
    parameter int unsigned SHIFT      = 0
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  in_valid,
    input  logic                  in_last,
    output logic                  in_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_sat
);

    localparam int unsigned PROD_W = prod_w(din0_WIDTH, din1_WIDTH);
    localparam int unsigned ACC_W  = acc_w(PROD_W, ACC_LEN);
    localparam int unsigned CNT_W  = (ACC_LEN > 1) ? clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ACC_LEN - 1);

    logic                     w_en;
    logic                     w_m_valid;
    logic                     w_m_last;
    logic signed [PROD_W-1:0] w_m_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_sum;
    logic                     w_close;
    sat_res_t                 w_sat;
    logic                     w_unused_hi;

    logic                     r_rdy;
    logic [CNT_W-1:0]         r_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_out_valid;
    logic [dout_WIDTH-1:0]    r_dout;
    logic                     r_sat;

    // One stall for every stage: bubbles only move when the output slot can move.
    assign w_en     = ~r_out_valid | out_ready;
    // r_rdy keeps in_ready low through reset and the first cycle after release.
    assign in_ready = r_rdy & w_en;

    myproject_mul_pipe_stage #(
        .DIN0_W    (din0_WIDTH),
        .DIN1_W    (din1_WIDTH),
        .NUM_STAGE (NUM_STAGE)
    ) u_mul (
        .i_clk   (ap_clk),
        .i_rst_n (ap_rst_n),
        .i_en    (w_en),
        .i_valid (in_valid & in_ready),
        .i_last  (in_last),
        .i_a     (din0),
        .i_b     (din1),
        .o_valid (w_m_valid),
        .o_last  (w_m_last),
        .o_prod  (w_m_prod)
    );

    assign w_prod_ext = ACC_W'(w_m_prod);

    always_comb begin
        w_sum   = w_prod_ext;
        w_close = w_m_valid;
        if (ACC_EN != 0) begin
            // First product of a group loads; later ones add.
            if (r_cnt != '0) begin
                w_sum = r_acc + w_prod_ext;
            end
            w_close = w_m_valid & (w_m_last | (r_cnt == CNT_MAX));
        end
    end

    assign w_sat       = sat_shift(MAX_W'(w_sum), SHIFT, dout_WIDTH);
    // Bits above dout_WIDTH are pure sign copies after clipping.
    assign w_unused_hi = ^w_sat.val[MAX_W-1:dout_WIDTH];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rdy <= 1'b0;
        end else begin
            r_rdy <= 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_sat       <= 1'b0;
        end else if (w_en) begin
            if (w_m_valid) begin
                if (w_close) begin
                    r_cnt <= '0;
                    r_acc <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_acc <= w_sum;
                end
            end
            r_out_valid <= w_close;
            if (w_close) begin
                r_dout <= w_sat.val[dout_WIDTH-1:0];
                r_sat  <= w_sat.sat;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign dout      = r_dout;
    assign out_sat   = r_sat;

endmodule

// File: tb/tb_myproject_mul_acc_pipe.sv
// Randomized and directed bench for myproject_mul_acc_pipe across four configurations:
//   u_a : ACC_EN=0, NUM_STAGE=2, dout 29
//   u_b : ACC_EN=1, ACC_LEN=9, NUM_STAGE=3, dout 29
//   u_c2: ACC_EN=0, NUM_STAGE=1, dout 16
//   u_c3: ACC_EN=0, NUM_STAGE=4, dout 16, SHIFT=4 (shares inputs with u_c2)
module tb_myproject_mul_acc_pipe;

    logic ap_clk   = 1'b0;
    logic ap_rst_n = 1'b1;
    always #5 ap_clk = ~ap_clk;

    int errors = 0;
    int checks = 0;

    logic [15:0] a_din0, b_din0, c_din0;
    logic [13:0] a_din1, b_din1, c_din1;
    logic        a_valid, a_last, a_ready, a_out_valid, a_out_ready, a_sat;
    logic        b_valid, b_last, b_ready, b_out_valid, b_out_ready, b_sat;
    logic        c_valid, c_out_ready;
    logic        c2_ready, c2_out_valid, c2_sat, c3_ready, c3_out_valid, c3_sat;
    logic [28:0] a_dout, b_dout;
    logic [15:0] c2_dout, c3_dout;

    // Stimulus and reference-model state.
    logic [15:0] a_q0[$], b_q0[$];
    logic [13:0] a_q1[$], b_q1[$];
    logic        b_ql[$];
    longint      a_exp_v[$], b_exp_v[$];
    logic        a_exp_s[$], b_exp_s[$];
    longint      a_got[$], b_got[$];
    longint      a_exp_sum, a_got_sum, b_exp_sum, b_got_sum;
    longint      mb_acc;
    int          mb_cnt;

    myproject_mul_acc_pipe #(
        .din0_WIDTH(16), .din1_WIDTH(14), .dout_WIDTH(29), .NUM_STAGE(2),
        .ACC_EN(0), .ACC_LEN(9), .SHIFT(0)
    ) u_a (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din0(a_din0), .din1(a_din1),
        .in_valid(a_valid), .in_last(a_last), .in_ready(a_ready), .dout(a_dout),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_sat(a_sat)
    );

    myproject_mul_acc_pipe #(
        .din0_WIDTH(16), .din1_WIDTH(14), .dout_WIDTH(29), .NUM_STAGE(3),
        .ACC_EN(1), .ACC_LEN(9), .SHIFT(0)
    ) u_b (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din0(b_din0), .din1(b_din1),
        .in_valid(b_valid), .in_last(b_last), .in_ready(b_ready), .dout(b_dout),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_sat(b_sat)
    );

    myproject_mul_acc_pipe #(
        .din0_WIDTH(16), .din1_WIDTH(14), .dout_WIDTH(16), .NUM_STAGE(1),
        .ACC_EN(0), .ACC_LEN(9), .SHIFT(0)
    ) u_c2 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din0(c_din0), .din1(c_din1),
        .in_valid(c_valid), .in_last(1'b0), .in_ready(c2_ready), .dout(c2_dout),
        .out_valid(c2_out_valid), .out_ready(c_out_ready), .out_sat(c2_sat)
    );

    myproject_mul_acc_pipe #(
        .din0_WIDTH(16), .din1_WIDTH(14), .dout_WIDTH(16), .NUM_STAGE(4),
        .ACC_EN(0), .ACC_LEN(9), .SHIFT(4)
    ) u_c3 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .din0(c_din0), .din1(c_din1),
        .in_valid(c_valid), .in_last(1'b0), .in_ready(c3_ready), .dout(c3_dout),
        .out_valid(c3_out_valid), .out_ready(c_out_ready), .out_sat(c3_sat)
    );

    // Floor shift then clip to a signed w-bit range.
    function automatic void sat_ref(input longint x, input int sh, input int w,
                                    output longint v, output logic s);
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (w - 1)) - 1;
        lo = -hi - 1;
        v  = x >>> sh;
        s  = 1'b0;
        if (v > hi) begin
            v = hi;
            s = 1'b1;
        end else if (v < lo) begin
            v = lo;
            s = 1'b1;
        end
    endfunction

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic run_a(input int ready_pct, input int valid_pct);
        int     idx = 0;
        int     cyc = 0;
        int     drain = 0;
        logic   held;
        logic [28:0] h_dout;
        logic   h_sat;
        longint ev;
        logic   es;
        a_got.delete();
        while (drain < 8 && cyc < 20000) begin
            a_out_ready = (int'($urandom_range(99)) < ready_pct);
            a_din0 = 16'($urandom);
            a_din1 = 14'($urandom);
            a_last = 1'($urandom_range(1));
            a_valid = 1'b0;
            if (idx < a_q0.size() && int'($urandom_range(99)) < valid_pct) begin
                a_valid = 1'b1;
                a_din0  = a_q0[idx];
                a_din1  = a_q1[idx];
            end
            #1;
            if (a_out_valid && a_out_ready) begin
                checks++;
                if (a_exp_v.size() == 0) begin
                    errors++;
                    $display("FAIL a_extra_output dout=%0d required no output", $signed(a_dout));
                end else begin
                    ev = a_exp_v.pop_front();
                    es = a_exp_s.pop_front();
                    if (a_dout !== 29'(ev) || a_sat !== es) begin
                        errors++;
                        $display("FAIL a_out dout=%0d sat=%0b required dout=%0d sat=%0b",
                                 $signed(a_dout), a_sat, ev, es);
                    end
                end
                a_got.push_back(longint'($signed(a_dout)));
                a_got_sum += longint'($signed(a_dout));
            end
            held   = a_out_valid && !a_out_ready;
            h_dout = a_dout;
            h_sat  = a_sat;
            if (a_valid && a_ready) begin
                sat_ref(longint'($signed(a_din0)) * longint'(a_din1), 0, 29, ev, es);
                a_exp_v.push_back(ev);
                a_exp_s.push_back(es);
                a_exp_sum += ev;
                idx++;
            end
            tick();
            cyc++;
            if (held) begin
                checks++;
                if (a_out_valid !== 1'b1 || a_dout !== h_dout || a_sat !== h_sat) begin
                    errors++;
                    $display("FAIL a_hold valid=%0b dout=%0d required valid=1 dout=%0d",
                             a_out_valid, $signed(a_dout), $signed(h_dout));
                end
            end
            if (idx == a_q0.size() && a_exp_v.size() == 0) drain++;
            else drain = 0;
        end
        a_valid     = 1'b0;
        a_out_ready = 1'b1;
        if (cyc >= 20000) begin
            checks++;
            errors++;
            $display("FAIL a_timeout accepted=%0d required %0d", idx, a_q0.size());
        end
    endtask

    task automatic run_b(input int ready_pct, input int valid_pct);
        int     idx = 0;
        int     cyc = 0;
        int     drain = 0;
        logic   held;
        logic [28:0] h_dout;
        logic   h_sat;
        longint ev;
        logic   es;
        b_got.delete();
        while (drain < 8 && cyc < 20000) begin
            b_out_ready = (int'($urandom_range(99)) < ready_pct);
            b_din0 = 16'($urandom);
            b_din1 = 14'($urandom);
            b_last = 1'($urandom_range(1));
            b_valid = 1'b0;
            if (idx < b_q0.size() && int'($urandom_range(99)) < valid_pct) begin
                b_valid = 1'b1;
                b_din0  = b_q0[idx];
                b_din1  = b_q1[idx];
                b_last  = b_ql[idx];
            end
            #1;
            if (b_out_valid && b_out_ready) begin
                checks++;
                if (b_exp_v.size() == 0) begin
                    errors++;
                    $display("FAIL b_extra_output dout=%0d required no output", $signed(b_dout));
                end else begin
                    ev = b_exp_v.pop_front();
                    es = b_exp_s.pop_front();
                    if (b_dout !== 29'(ev) || b_sat !== es) begin
                        errors++;
                        $display("FAIL b_out dout=%0d sat=%0b required dout=%0d sat=%0b",
                                 $signed(b_dout), b_sat, ev, es);
                    end
                end
                b_got.push_back(longint'($signed(b_dout)));
                b_got_sum += longint'($signed(b_dout));
            end
            held   = b_out_valid && !b_out_ready;
            h_dout = b_dout;
            h_sat  = b_sat;
            if (b_valid && b_ready) begin
                mb_acc += longint'($signed(b_din0)) * longint'(b_din1);
                mb_cnt++;
                if (mb_cnt == 9 || b_last) begin
                    sat_ref(mb_acc, 0, 29, ev, es);
                    b_exp_v.push_back(ev);
                    b_exp_s.push_back(es);
                    b_exp_sum += ev;
                    mb_acc = 0;
                    mb_cnt = 0;
                end
                idx++;
            end
            tick();
            cyc++;
            if (held) begin
                checks++;
                if (b_out_valid !== 1'b1 || b_dout !== h_dout || b_sat !== h_sat) begin
                    errors++;
                    $display("FAIL b_hold valid=%0b dout=%0d required valid=1 dout=%0d",
                             b_out_valid, $signed(b_dout), $signed(h_dout));
                end
            end
            if (idx == b_q0.size() && b_exp_v.size() == 0) drain++;
            else drain = 0;
        end
        b_valid     = 1'b0;
        b_out_ready = 1'b1;
        b_q0.delete();
        b_q1.delete();
        b_ql.delete();
        if (cyc >= 20000) begin
            checks++;
            errors++;
            $display("FAIL b_timeout accepted=%0d", idx);
        end
    endtask

    task automatic push_b(input int n, input logic [15:0] d0, input logic [13:0] d1,
                          input int last_at);
        for (int i = 1; i <= n; i++) begin
            b_q0.push_back(d0);
            b_q1.push_back(d1);
            b_ql.push_back(i == last_at);
        end
    endtask

    // Drives one beat into u_c2/u_c3 and captures each result with its latency in edges.
    task automatic c_beat(input logic [15:0] d0, input logic [13:0] d1,
                          output logic [15:0] v2, output logic s2, output int l2,
                          output logic [15:0] v3, output logic s3, output int l3);
        int n = 0;
        l2 = 0;
        l3 = 0;
        v2 = '0;
        v3 = '0;
        s2 = 1'b0;
        s3 = 1'b0;
        c_din0  = d0;
        c_din1  = d1;
        c_valid = 1'b1;
        while ((l2 == 0 || l3 == 0) && n < 12) begin
            tick();
            n++;
            if (n == 1) c_valid = 1'b0;
            if (c2_out_valid && l2 == 0) begin
                l2 = n;
                v2 = c2_dout;
                s2 = c2_sat;
            end
            if (c3_out_valid && l3 == 0) begin
                l3 = n;
                v3 = c3_dout;
                s3 = c3_sat;
            end
        end
        tick();
    endtask

    task automatic test_reset();
        #1;
        ap_rst_n = 1'b0;
        repeat (3) @(posedge ap_clk);
        #1;
        checks++;
        if ({a_ready, a_out_valid, a_sat, a_dout, b_ready, b_out_valid, b_sat, b_dout} !== '0) begin
            errors++;
            $display("FAIL reset_ab ready=%0b/%0b valid=%0b/%0b dout=%0d/%0d required all 0",
                     a_ready, b_ready, a_out_valid, b_out_valid, a_dout, b_dout);
        end
        checks++;
        if ({c2_ready, c2_out_valid, c2_sat, c2_dout, c3_ready, c3_out_valid, c3_sat, c3_dout}
            !== '0) begin
            errors++;
            $display("FAIL reset_c ready=%0b/%0b valid=%0b/%0b required all 0",
                     c2_ready, c3_ready, c2_out_valid, c3_out_valid);
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        #1;
        checks++;
        if (a_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_before_edge in_ready=%0b required 0", a_ready);
        end
        tick();
        checks++;
        if ({a_ready, b_ready, c2_ready, c3_ready} !== 4'b1111) begin
            errors++;
            $display("FAIL ready_after_release in_ready=%b required 1111",
                     {a_ready, b_ready, c2_ready, c3_ready});
        end
    endtask

    task automatic test_latency();
        int n = 0;
        a_out_ready = 1'b1;
        a_din0  = 16'hFFFD;
        a_din1  = 14'd5;
        a_valid = 1'b1;
        while (n < 12) begin
            tick();
            n++;
            if (n == 1) a_valid = 1'b0;
            if (a_out_valid) break;
        end
        checks++;
        if (n !== 3 || a_dout !== 29'h1FFFFFF1 || a_sat !== 1'b0) begin
            errors++;
            $display("FAIL latency cycles=%0d dout=%0d sat=%0b required cycles=3 dout=-15 sat=0",
                     n, $signed(a_dout), a_sat);
        end
        tick();
    endtask

    task automatic test_acc_full();
        push_b(9, 16'd100, 14'd200, 0);
        run_b(100, 100);
        checks++;
        if (b_got.size() != 1 || b_got[0] !== 64'sd180000) begin
            errors++;
            $display("FAIL acc_full outputs=%0d first=%0d required 1 output of 180000",
                     b_got.size(), (b_got.size() > 0) ? b_got[0] : -1);
        end
    endtask

    task automatic test_acc_last();
        // Early close, then a full group right behind it, then both close conditions at once.
        push_b(4, 16'd1, 14'd1, 4);
        push_b(9, 16'd1, 14'd1, 0);
        push_b(9, 16'd1, 14'd1, 9);
        run_b(100, 100);
        checks++;
        if (b_got.size() != 3) begin
            errors++;
            $display("FAIL acc_last_count outputs=%0d required 3", b_got.size());
        end else begin
            checks++;
            if (b_got[0] !== 64'sd4 || b_got[1] !== 64'sd9 || b_got[2] !== 64'sd9) begin
                errors++;
                $display("FAIL acc_last_values got=%0d,%0d,%0d required 4,9,9",
                         b_got[0], b_got[1], b_got[2]);
            end
        end
    endtask

    task automatic test_saturation();
        logic [15:0] v2, v3;
        logic        s2, s3;
        int          l2, l3;
        c_beat(16'h7FFF, 14'h3FFF, v2, s2, l2, v3, s3, l3);
        checks++;
        if (v2 !== 16'h7FFF || s2 !== 1'b1 || l2 != 2) begin
            errors++;
            $display("FAIL sat_pos dout=%0d sat=%0b lat=%0d required 32767 1 2",
                     $signed(v2), s2, l2);
        end
        checks++;
        if (v3 !== 16'h7FFF || s3 !== 1'b1 || l3 != 5) begin
            errors++;
            $display("FAIL sat_pos_shift dout=%0d sat=%0b lat=%0d required 32767 1 5",
                     $signed(v3), s3, l3);
        end
        c_beat(16'h8000, 14'h3FFF, v2, s2, l2, v3, s3, l3);
        checks++;
        if (v2 !== 16'h8000 || s2 !== 1'b1 || v3 !== 16'h8000 || s3 !== 1'b1) begin
            errors++;
            $display("FAIL sat_neg dout=%0d/%0d sat=%0b/%0b required -32768/-32768 1/1",
                     $signed(v2), $signed(v3), s2, s3);
        end
        c_beat(16'hFFFF, 14'd1, v2, s2, l2, v3, s3, l3);
        checks++;
        if (v2 !== 16'hFFFF || s2 !== 1'b0 || v3 !== 16'hFFFF || s3 !== 1'b0) begin
            errors++;
            $display("FAIL floor_m1 dout=%0d/%0d sat=%0b/%0b required -1/-1 0/0",
                     $signed(v2), $signed(v3), s2, s3);
        end
        c_beat(16'hFFEF, 14'd1, v2, s2, l2, v3, s3, l3);
        checks++;
        if (v2 !== 16'hFFEF || v3 !== 16'hFFFE || s2 !== 1'b0 || s3 !== 1'b0) begin
            errors++;
            $display("FAIL floor_m17 dout=%0d/%0d sat=%0b/%0b required -17/-2 0/0",
                     $signed(v2), $signed(v3), s2, s3);
        end
        c_beat(16'h7FFF, 14'd1, v2, s2, l2, v3, s3, l3);
        checks++;
        if (v2 !== 16'h7FFF || s2 !== 1'b0 || v3 !== 16'd2047 || s3 !== 1'b0) begin
            errors++;
            $display("FAIL edge_max dout=%0d/%0d sat=%0b/%0b required 32767/2047 0/0",
                     $signed(v2), $signed(v3), s2, s3);
        end
    endtask

    task automatic test_random_a();
        for (int i = 0; i < 300; i++) begin
            a_q0.push_back(16'($urandom));
            a_q1.push_back(14'($urandom));
        end
        a_exp_sum = 0;
        a_got_sum = 0;
        run_a(30, 85);
        checks++;
        if (a_got.size() != 300 || a_got_sum !== a_exp_sum) begin
            errors++;
            $display("FAIL random_a outputs=%0d sum=%0d required 300 sum=%0d",
                     a_got.size(), a_got_sum, a_exp_sum);
        end
    endtask

    task automatic test_random_b();
        for (int i = 0; i < 150; i++) begin
            b_q0.push_back(16'($urandom));
            b_q1.push_back(14'($urandom_range(2047)));
            b_ql.push_back($urandom_range(99) < 10);
        end
        b_exp_sum = 0;
        b_got_sum = 0;
        run_b(30, 80);
        checks++;
        if (b_got_sum !== b_exp_sum || b_got.size() == 0) begin
            errors++;
            $display("FAIL random_b outputs=%0d sum=%0d required sum=%0d",
                     b_got.size(), b_got_sum, b_exp_sum);
        end
        // Close any group the random stream left open before the reset test.
        if (mb_cnt != 0) begin
            push_b(1, 16'd0, 14'd0, 1);
            run_b(100, 100);
        end
    endtask

    task automatic test_reset_mid_group();
        push_b(5, 16'd1, 14'd1, 0);
        run_b(100, 100);
        checks++;
        if (b_got.size() != 0) begin
            errors++;
            $display("FAIL mid_group_early outputs=%0d required 0", b_got.size());
        end
        @(negedge ap_clk);
        ap_rst_n = 1'b0;
        #1;
        checks++;
        if (b_out_valid !== 1'b0 || b_dout !== '0 || b_sat !== 1'b0 || b_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_group_reset valid=%0b dout=%0d ready=%0b required 0 0 0",
                     b_out_valid, b_dout, b_ready);
        end
        mb_acc = 0;
        mb_cnt = 0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        tick();
        tick();
        push_b(9, 16'd1, 14'd1, 0);
        run_b(100, 100);
        checks++;
        if (b_got.size() != 1 || b_got[0] !== 64'sd9) begin
            errors++;
            $display("FAIL after_reset outputs=%0d first=%0d required 1 output of 9",
                     b_got.size(), (b_got.size() > 0) ? b_got[0] : -1);
        end
    endtask

    initial begin
        a_din0 = '0; a_din1 = '0; a_valid = 1'b0; a_last = 1'b0; a_out_ready = 1'b1;
        b_din0 = '0; b_din1 = '0; b_valid = 1'b0; b_last = 1'b0; b_out_ready = 1'b1;
        c_din0 = '0; c_din1 = '0; c_valid = 1'b0; c_out_ready = 1'b1;
        mb_acc = 0;
        mb_cnt = 0;
        a_exp_sum = 0; a_got_sum = 0; b_exp_sum = 0; b_got_sum = 0;
        test_reset();
        test_latency();
        test_acc_full();
        test_acc_last();
        test_saturation();
        test_random_a();
        test_random_b();
        test_reset_mid_group();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
